// File: rtl/sa_loadable_weights_pkg.sv
// Shared types and elaboration helpers for the loadable-weight systolic array.
package sa_loadable_weights_pkg;

  typedef enum logic [1:0] {
    SA_EMPTY,
    SA_LOADING,
    SA_READY
  } sa_state_t;

  // Partial sums must hold a full weight x activation product without loss.
  function automatic bit acc_width_ok(input int acc_size, input int weight_size,
                                      input int activation_size);
    return acc_size >= (weight_size + activation_size);
  endfunction

endpackage

// File: rtl/sa_loadable_weights_if.sv
// Weight-load, activation and result bus of the systolic array.
// Handshake: a beat transfers on a rising edge where valid and ready are both high;
// ready may depend on valid only as documented in the array (in_ready = !w_load_valid in READY).
interface sa_loadable_weights_if #(
  parameter int SA_SIZE         = 8,
  parameter int WEIGHT_SIZE     = 8,
  parameter int ACTIVATION_SIZE = 8,
  parameter int ACC_SIZE        = 32
);
  logic                               w_load_valid;
  logic                               w_load_ready;
  logic [SA_SIZE*WEIGHT_SIZE-1:0]     w_load_row;
  logic                               in_valid;
  logic                               in_ready;
  logic [SA_SIZE*ACTIVATION_SIZE-1:0] inputs;
  logic                               out_valid;
  logic [SA_SIZE*ACC_SIZE-1:0]        outputs;

  modport master (
    output w_load_valid, w_load_row, in_valid, inputs,
    input  w_load_ready, in_ready, out_valid, outputs
  );

  modport slave (
    input  w_load_valid, w_load_row, in_valid, inputs,
    output w_load_ready, in_ready, out_valid, outputs
  );
endinterface

// File: rtl/sa_pe_acc.sv
// Combinational signed multiply-accumulate for one PE; wraps modulo 2^ACC_SIZE.
module sa_pe_acc #(
  parameter int WEIGHT_SIZE     = 8,
  parameter int ACTIVATION_SIZE = 8,
  parameter int ACC_SIZE        = 32
) (
  input  logic signed [ACTIVATION_SIZE-1:0] act_i,
  input  logic signed [WEIGHT_SIZE-1:0]     wgt_i,
  input  logic signed [ACC_SIZE-1:0]        acc_i,
  output logic signed [ACC_SIZE-1:0]        acc_o
);
  logic signed [ACC_SIZE-1:0] act_ext;
  logic signed [ACC_SIZE-1:0] wgt_ext;

  assign act_ext = {{(ACC_SIZE-ACTIVATION_SIZE){act_i[ACTIVATION_SIZE-1]}}, act_i};
  assign wgt_ext = {{(ACC_SIZE-WEIGHT_SIZE){wgt_i[WEIGHT_SIZE-1]}}, wgt_i};
  assign acc_o   = acc_i + act_ext * wgt_ext;
endmodule

// File: rtl/sa_loadable_weights.sv
// Weight-stationary systolic array with run-time weight loading, one row per beat.
// Columns accumulate downward; activations pass rightward; both advance only on accepted beats.
module sa_loadable_weights
  import sa_loadable_weights_pkg::*;
#(
  parameter int SA_SIZE         = 8,
  parameter int WEIGHT_SIZE     = 8,
  parameter int ACTIVATION_SIZE = 8,
  parameter int ACC_SIZE        = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  sa_loadable_weights_if.slave  bus,
  output sa_state_t             state_o
);
  localparam int CNT_W = $clog2(SA_SIZE);

  if (!acc_width_ok(ACC_SIZE, WEIGHT_SIZE, ACTIVATION_SIZE)) begin : g_acc_check
    $error("ACC_SIZE must be at least WEIGHT_SIZE + ACTIVATION_SIZE");
  end

  sa_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wr_row;
  logic             load_beat, advance, flush;

  logic signed [WEIGHT_SIZE-1:0]     wgt_q  [SA_SIZE][SA_SIZE];
  logic signed [ACTIVATION_SIZE-1:0] in_q   [SA_SIZE][SA_SIZE-1];
  logic signed [ACC_SIZE-1:0]        acc_q  [SA_SIZE-1][SA_SIZE];
  logic signed [ACTIVATION_SIZE-1:0] pe_in  [SA_SIZE][SA_SIZE];
  logic signed [ACC_SIZE-1:0]        acc_in [SA_SIZE][SA_SIZE];
  logic signed [ACC_SIZE-1:0]        pe_out [SA_SIZE][SA_SIZE];
  logic [SA_SIZE*ACC_SIZE-1:0]       outputs_q;
  logic                              out_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SA_EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      SA_EMPTY, SA_READY: begin
        if (load_beat) begin
          state_d = SA_LOADING;
          cnt_d   = CNT_W'(1);
        end
      end
      SA_LOADING: begin
        if (load_beat) begin
          if (cnt_q == CNT_W'(SA_SIZE-1)) begin
            state_d = SA_READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = SA_EMPTY;
        cnt_d   = '0;
      end
    endcase
  end

  // A pending weight load blocks activations so no result mixes two weight sets.
  always_comb begin
    bus.w_load_ready = 1'b1;
    bus.in_ready     = (state_q == SA_READY) && !bus.w_load_valid;
  end

  assign load_beat = bus.w_load_valid && bus.w_load_ready;
  assign advance   = bus.in_valid && bus.in_ready;
  assign flush     = load_beat && (state_q == SA_READY);
  assign wr_row    = (state_q == SA_LOADING) ? cnt_q : '0;
  assign state_o   = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < SA_SIZE; r++)
        for (int c = 0; c < SA_SIZE; c++)
          wgt_q[r][c] <= '0;
    end else if (load_beat) begin
      for (int c = 0; c < SA_SIZE; c++)
        wgt_q[wr_row][c] <= bus.w_load_row[c*WEIGHT_SIZE +: WEIGHT_SIZE];
    end
  end

  for (genvar r = 0; r < SA_SIZE; r++) begin : g_row
    for (genvar c = 0; c < SA_SIZE; c++) begin : g_col
      if (c == 0) begin : g_in_edge
        assign pe_in[r][c] = bus.inputs[r*ACTIVATION_SIZE +: ACTIVATION_SIZE];
      end else begin : g_in_pass
        assign pe_in[r][c] = in_q[r][c-1];
      end
      if (r == 0) begin : g_acc_top
        assign acc_in[r][c] = '0;
      end else begin : g_acc_chain
        assign acc_in[r][c] = acc_q[r-1][c];
      end
      sa_pe_acc #(
        .WEIGHT_SIZE    (WEIGHT_SIZE),
        .ACTIVATION_SIZE(ACTIVATION_SIZE),
        .ACC_SIZE       (ACC_SIZE)
      ) u_pe (
        .act_i(pe_in[r][c]),
        .wgt_i(wgt_q[r][c]),
        .acc_i(acc_in[r][c]),
        .acc_o(pe_out[r][c])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int r = 0; r < SA_SIZE; r++)
        for (int c = 0; c < SA_SIZE-1; c++)
          in_q[r][c] <= '0;
      for (int r = 0; r < SA_SIZE-1; r++)
        for (int c = 0; c < SA_SIZE; c++)
          acc_q[r][c] <= '0;
      outputs_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= advance;
      if (advance) begin
        for (int r = 0; r < SA_SIZE; r++)
          for (int c = 0; c < SA_SIZE-1; c++)
            in_q[r][c] <= pe_in[r][c];
        for (int r = 0; r < SA_SIZE-1; r++)
          for (int c = 0; c < SA_SIZE; c++)
            acc_q[r][c] <= pe_out[r][c];
        for (int c = 0; c < SA_SIZE; c++)
          outputs_q[c*ACC_SIZE +: ACC_SIZE] <= pe_out[SA_SIZE-1][c];
      end
    end
  end

  assign bus.outputs   = outputs_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_sa_loadable_weights.sv
// Bench for sa_loadable_weights: 2x2 array at 32-bit and 16-bit accumulator widths.
module tb_sa_loadable_weights;
  import sa_loadable_weights_pkg::*;

  localparam int SA  = 2;
  localparam int W   = 8;
  localparam int A   = 8;
  localparam int ACC = 32;

  logic      clk;
  logic      reset;
  sa_state_t st, st16;
  int        total, bad;

  sa_loadable_weights_if #(.SA_SIZE(SA), .WEIGHT_SIZE(W), .ACTIVATION_SIZE(A), .ACC_SIZE(ACC)) bus ();
  sa_loadable_weights_if #(.SA_SIZE(SA), .WEIGHT_SIZE(W), .ACTIVATION_SIZE(A), .ACC_SIZE(16)) bus16 ();

  sa_loadable_weights #(.SA_SIZE(SA), .WEIGHT_SIZE(W), .ACTIVATION_SIZE(A), .ACC_SIZE(ACC)) dut (
    .clk(clk), .reset(reset), .bus(bus), .state_o(st)
  );
  sa_loadable_weights #(.SA_SIZE(SA), .WEIGHT_SIZE(W), .ACTIVATION_SIZE(A), .ACC_SIZE(16)) dut16 (
    .clk(clk), .reset(reset), .bus(bus16), .state_o(st16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: loaded weights and accepted activation beats since the last load.
  int                  w_m [SA][SA];
  logic [SA*A-1:0]     hist_q[$];
  logic [SA*ACC-1:0]   exp_q[$];
  logic [SA*ACC-1:0]   last_out;
  bit                  loaded;

  // Column c after accepted beat n sums row r's activation from beat n-(SA-1-r)-c.
  function automatic logic [SA*ACC-1:0] model_out(input int n);
    logic [SA*ACC-1:0] res;
    logic [SA*A-1:0]   beat;
    longint            sum;
    int                idx;
    res = '0;
    for (int c = 0; c < SA; c++) begin
      sum = 0;
      for (int r = 0; r < SA; r++) begin
        idx = n - (SA-1-r) - c;
        if (idx >= 0) begin
          beat = hist_q[idx];
          sum  = sum + longint'($signed(beat[r*A +: A])) * longint'(w_m[r][c]);
        end
      end
      res[c*ACC +: ACC] = sum[ACC-1:0];
    end
    return res;
  endfunction

  task automatic set_w_model(input int r, input logic [SA*W-1:0] row);
    for (int c = 0; c < SA; c++) w_m[r][c] = int'($signed(row[c*W +: W]));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    bus.w_load_valid = 1'b0; bus.w_load_row = '0; bus.in_valid = 1'b0; bus.inputs = '0;
    bus16.w_load_valid = 1'b0; bus16.w_load_row = '0; bus16.in_valid = 1'b0; bus16.inputs = '0;
    tick; tick;
    reset = 1'b0;
    loaded = 1'b0; hist_q.delete(); exp_q.delete(); last_out = '0;
    for (int r = 0; r < SA; r++) for (int c = 0; c < SA; c++) w_m[r][c] = 0;
  endtask

  task automatic load_weights(input logic [SA*W-1:0] r0, input logic [SA*W-1:0] r1);
    logic [SA*W-1:0] rows [SA];
    sa_state_t       exp_st;
    rows[0] = r0; rows[1] = r1;
    for (int r = 0; r < SA; r++) begin
      bus.w_load_valid = 1'b1;
      bus.w_load_row   = rows[r];
      #1;
      total++;
      if (bus.w_load_ready !== 1'b1) begin
        bad++; $display("FAIL load_ready row=%0d got=%b exp=1", r, bus.w_load_ready);
      end
      tick;
      if (r == 0) begin
        if (loaded) last_out = '0;
        loaded = 1'b0; hist_q.delete(); exp_q.delete();
      end
      set_w_model(r, rows[r]);
      exp_st = (r == SA-1) ? SA_READY : SA_LOADING;
      total++;
      if (st !== exp_st) begin
        bad++; $display("FAIL load_state row=%0d got=%0d exp=%0d", r, st, exp_st);
      end
    end
    bus.w_load_valid = 1'b0;
    loaded = 1'b1;
  endtask

  // Drives one cycle of activation; the scoreboard pushes on acceptance and pops after the edge.
  task automatic drive_beat(input bit valid, input logic [SA*A-1:0] act);
    logic [SA*ACC-1:0] exp_v;
    bit                adv;
    bus.in_valid = valid;
    bus.inputs   = act;
    #1;
    total++;
    if (bus.in_ready !== loaded) begin
      bad++; $display("FAIL beat_in_ready got=%b exp=%b", bus.in_ready, loaded);
    end
    adv = valid && loaded;
    if (adv) begin
      hist_q.push_back(act);
      exp_q.push_back(model_out(hist_q.size() - 1));
    end
    tick;
    bus.in_valid = 1'b0;
    if (adv) begin
      exp_v = exp_q.pop_front();
      last_out = exp_v;
      total++;
      if (bus.out_valid !== 1'b1) begin
        bad++; $display("FAIL beat_out_valid got=%b exp=1", bus.out_valid);
      end
    end else begin
      exp_v = last_out;
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++; $display("FAIL idle_out_valid got=%b exp=0", bus.out_valid);
      end
    end
    total++;
    if (bus.outputs !== exp_v) begin
      bad++; $display("FAIL beat_outputs got=%h exp=%h", bus.outputs, exp_v);
    end
  endtask

  task automatic test_reset;
    do_reset;
    for (int i = 0; i < 5; i++) tick;
    total++;
    if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    total++;
    if (bus.w_load_ready !== 1'b1) begin bad++; $display("FAIL reset_w_ready got=%b exp=1", bus.w_load_ready); end
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++;
    if (bus.outputs !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", bus.outputs); end
    total++;
    if (st !== SA_EMPTY) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", st, SA_EMPTY); end
  endtask

  task automatic test_compute;
    logic [SA*ACC-1:0] want;
    do_reset;
    load_weights({8'd2, 8'd1}, {8'd4, 8'd3});
    want = {32'd38, 32'd26};
    for (int k = 0; k < 4; k++) begin
      drive_beat(1'b1, {8'd7, 8'd5});
      if (k >= 2) begin
        total++;
        if (bus.outputs !== want) begin
          bad++; $display("FAIL compute_steady k=%0d got=%h exp=%h", k, bus.outputs, want);
        end
      end
    end
  endtask

  task automatic test_stall;
    do_reset;
    load_weights({8'd2, 8'd1}, {8'd4, 8'd3});
    for (int k = 0; k < 8; k++)
      drive_beat(k % 2 == 0, SA*A'($urandom_range(0, 65535)));
  endtask

  task automatic test_random;
    do_reset;
    load_weights(SA*W'($urandom_range(0, 65535)), SA*W'($urandom_range(0, 65535)));
    for (int k = 0; k < 14; k++)
      drive_beat(1'($urandom_range(0, 1)), SA*A'($urandom_range(0, 65535)));
  endtask

  task automatic test_wrap;
    logic [31:0] exp16 [4];
    exp16[0] = {16'h0000, 16'h4000};
    exp16[1] = {16'h4000, 16'h8000};
    exp16[2] = {16'h8000, 16'h8000};
    exp16[3] = {16'h8000, 16'h8000};
    do_reset;
    bus16.w_load_valid = 1'b1;
    bus16.w_load_row   = 16'h8080;
    tick; tick;
    bus16.w_load_valid = 1'b0;
    total++;
    if (st16 !== SA_READY) begin bad++; $display("FAIL wrap_state got=%0d exp=%0d", st16, SA_READY); end
    bus16.in_valid = 1'b1;
    bus16.inputs   = 16'h8080;
    for (int k = 0; k < 4; k++) begin
      tick;
      total++;
      if (bus16.outputs !== exp16[k] || bus16.out_valid !== 1'b1) begin
        bad++; $display("FAIL wrap_outputs k=%0d got=%h/%b exp=%h/1", k, bus16.outputs, bus16.out_valid, exp16[k]);
      end
    end
    bus16.in_valid = 1'b0;
  endtask

  task automatic test_reload_priority;
    do_reset;
    load_weights({8'd2, 8'd1}, {8'd4, 8'd3});
    for (int k = 0; k < 3; k++) drive_beat(1'b1, {8'd7, 8'd5});
    bus.in_valid = 1'b1; bus.inputs = {8'd9, 8'd11};
    bus.w_load_valid = 1'b1; bus.w_load_row = {8'd1, 8'hFF};
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reload_in_ready got=%b exp=0", bus.in_ready); end
    tick;
    bus.in_valid = 1'b0;
    total++;
    if (st !== SA_LOADING) begin bad++; $display("FAIL reload_state got=%0d exp=%0d", st, SA_LOADING); end
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reload_out_valid got=%b exp=0", bus.out_valid); end
    total++;
    if (bus.outputs !== '0) begin bad++; $display("FAIL reload_outputs got=%h exp=0", bus.outputs); end
    loaded = 1'b0; hist_q.delete(); exp_q.delete(); last_out = '0;
    set_w_model(0, {8'd1, 8'hFF});
    bus.w_load_row = {8'd2, 8'd3};
    tick;
    bus.w_load_valid = 1'b0;
    set_w_model(1, {8'd2, 8'd3});
    loaded = 1'b1;
    total++;
    if (st !== SA_READY) begin bad++; $display("FAIL reload_ready got=%0d exp=%0d", st, SA_READY); end
    for (int k = 0; k < 5; k++) drive_beat(1'b1, SA*A'($urandom_range(0, 65535)));
  endtask

  task automatic test_reset_midload;
    do_reset;
    bus.w_load_valid = 1'b1; bus.w_load_row = {8'd5, 8'd6};
    tick;
    bus.w_load_valid = 1'b0;
    total++;
    if (st !== SA_LOADING) begin bad++; $display("FAIL midload_state got=%0d exp=%0d", st, SA_LOADING); end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    total++;
    if (st !== SA_EMPTY) begin bad++; $display("FAIL midload_reset got=%0d exp=%0d", st, SA_EMPTY); end
    loaded = 1'b0;
    drive_beat(1'b1, {8'd3, 8'd4});
    load_weights({8'hFE, 8'd7}, {8'd3, 8'h81});
    for (int k = 0; k < 4; k++) drive_beat(1'b1, SA*A'($urandom_range(0, 65535)));
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset;
    test_compute;
    test_stall;
    test_random;
    test_wrap;
    test_reload_priority;
    test_reset_midload;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
